// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counting timer: register offsets,
// CTRL field layout, mode codes and FSM state encoding.
package timer_counter_pkg;

    // Register select values (byte address [3:2])
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;
    localparam logic [1:0] TC_RSVD   = 2'd3;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IM_BIT   = 3;
    localparam int unsigned CTRL_W        = 4;

    // MODE codes; 2 and 3 fall back to one-shot behaviour
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } tc_state_e;

    // Field order matches the CTRL bit positions above
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tc_ctrl_t;

    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Data-bus view of the timer as seen from the CPU MEM stage: select, strobe,
// write data, combinational read data and the interrupt request.
interface timer_counter_if #(
    parameter int unsigned CNT_W = 32
);
    logic [1:0]       A;
    logic             WE;
    logic [CNT_W-1:0] WD;
    logic [CNT_W-1:0] RD;
    logic             IRQ;

    modport master (
        output A,
        output WE,
        output WD,
        input  RD,
        input  IRQ
    );

    modport slave (
        input  A,
        input  WE,
        input  WD,
        output RD,
        output IRQ
    );
endinterface

// File: rtl/timer_counter.sv
// Down-counting timer with one-shot and auto-reload modes: control FSM, COUNT
// datapath, CTRL/PRESET registers and a zero-latency read mux.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int unsigned      CNT_W      = 32,
    parameter logic [CNT_W-1:0] PRESET_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    timer_counter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    tc_state_e        state_q, state_d;
    tc_ctrl_t         ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_pend_q, irq_pend_d;

    logic wr_ctrl;
    logic wr_preset;

    assign wr_ctrl   = bus.WE && (bus.A == TC_CTRL);
    assign wr_preset = bus.WE && (bus.A == TC_PRESET);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ctrl_q     <= '0;
            preset_q   <= PRESET_RST;
            count_q    <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_pend_d = irq_pend_q;

        unique case (state_q)
            StIdle: begin
                if (ctrl_q.en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!ctrl_q.en) begin
                    state_d = StIdle;
                end else if (count_q > CntOne) begin
                    count_d = count_q - CntOne;
                end else begin
                    // PRESET of 0 or 1 lands here too, so COUNT never wraps
                    count_d = '0;
                    state_d = StInt;
                end
            end
            StInt: begin
                if (is_reload(ctrl_q.mode)) begin
                    state_d = StLoad;
                end else begin
                    ctrl_d.en  = 1'b0;
                    irq_pend_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Bus writes come last so they override the FSM's EN clear and pend set
        if (wr_ctrl) begin
            ctrl_d     = tc_ctrl_t'(bus.WD[CTRL_W-1:0]);
            irq_pend_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d   = bus.WD;
            irq_pend_d = 1'b0;
        end
    end

    always_comb begin
        bus.RD = '0;
        unique case (bus.A)
            TC_CTRL:   bus.RD = {{(CNT_W - CTRL_W){1'b0}}, ctrl_q};
            TC_PRESET: bus.RD = preset_q;
            TC_COUNT:  bus.RD = count_q;
            TC_RSVD:   bus.RD = '0;
            default:   bus.RD = '0;
        endcase
    end

    // Auto-reload pulses for the single INT cycle; one-shot holds until cleared
    assign bus.IRQ = ctrl_q.im
                     & (irq_pend_q | ((state_q == StInt) & is_reload(ctrl_q.mode)));

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios plus random bus traffic, checked
// against a cycle-level behavioural model of the register/timer semantics.
module tb_timer_counter;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    timer_counter_if #(.CNT_W(32)) bus_if ();

    timer_counter #(
        .CNT_W      (32),
        .PRESET_RST (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int          m_phase;
    bit          m_en;
    bit [1:0]    m_mode;
    bit          m_im;
    bit          m_pend;
    bit [31:0]   m_preset;
    bit [31:0]   m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_en     = 1'b0;
        m_mode   = 2'd0;
        m_im     = 1'b0;
        m_pend   = 1'b0;
        m_preset = 32'h0;
        m_count  = 32'h0;
    endtask

    task automatic model_step(input logic [1:0] a, input logic we, input logic [31:0] wd);
        int        nph;
        bit        nen;
        bit        npend;
        bit [31:0] ncnt;
        nph   = m_phase;
        nen   = m_en;
        npend = m_pend;
        ncnt  = m_count;
        case (m_phase)
            PH_IDLE: if (m_en) nph = PH_LOAD;
            PH_LOAD: begin
                ncnt = m_preset;
                nph  = PH_CNT;
            end
            PH_CNT: begin
                if (!m_en) nph = PH_IDLE;
                else if (m_count > 1) ncnt = m_count - 1;
                else begin
                    ncnt = 0;
                    nph  = PH_INT;
                end
            end
            default: begin
                if (m_mode == 2'd1) nph = PH_LOAD;
                else begin
                    nen   = 1'b0;
                    npend = 1'b1;
                    nph   = PH_IDLE;
                end
            end
        endcase
        if (we && a == 2'd0) begin
            nen    = wd[0];
            m_mode = wd[2:1];
            m_im   = wd[3];
            npend  = 1'b0;
        end
        if (we && a == 2'd1) begin
            m_preset = wd;
            npend    = 1'b0;
        end
        m_phase = nph;
        m_en    = nen;
        m_pend  = npend;
        m_count = ncnt;
    endtask

    function automatic logic [31:0] m_rd(input int a);
        case (a)
            0:       return {28'h0, m_im, m_mode, m_en};
            1:       return m_preset;
            2:       return m_count;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_irq();
        return m_im && (m_pend || (m_phase == PH_INT && m_mode == 2'd1));
    endfunction

    task automatic check_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            bus_if.A = 2'(a);
            #1;
            chk($sformatf("%s_rd%0d", tag, a), bus_if.RD, m_rd(a));
        end
        chk({tag, "_irq"}, {31'h0, bus_if.IRQ}, {31'h0, m_irq()});
    endtask

    // Drive one bus cycle, advance the model at the edge, then check every register
    task automatic step(input logic [1:0] a, input logic we, input logic [31:0] wd,
                        input string tag);
        bus_if.A  = a;
        bus_if.WE = we;
        bus_if.WD = wd;
        @(posedge clk);
        if (rst) model_step(a, we, wd);
        else model_reset();
        #1;
        bus_if.WE = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(2'd0, 1'b0, 32'h0, tag);
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] v);
        bus_if.A = a;
        #1;
        v = bus_if.RD;
    endtask

    initial begin
        logic [31:0] v;
        logic [15:0] irq_hist;
        logic [2:0]  irq3;
        logic [1:0]  ra;
        logic        rwe;
        logic [31:0] rwd;

        bus_if.A  = 2'd0;
        bus_if.WE = 1'b0;
        bus_if.WD = 32'h0;
        model_reset();

        // Reset held for 3 cycles
        #1 rst = 1'b0;
        idle(3, "rst");
        peek(2'd0, v); chk("rst_ctrl", v, 32'h0);
        peek(2'd1, v); chk("rst_preset", v, 32'h0);
        peek(2'd2, v); chk("rst_count", v, 32'h0);
        chk("rst_irq", {31'h0, bus_if.IRQ}, 32'h0);
        rst = 1'b1;
        idle(1, "rel");

        // One-shot, interrupt unmasked
        step(2'd1, 1'b1, 32'd3, "os_pre");
        step(2'd0, 1'b1, 32'h9, "os_ctl");
        idle(2, "os_run");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle(1, "os_run");
            peek(2'd2, v);
            chk($sformatf("os_count%0d", i), v, 32'(3 - i));
        end
        idle(1, "os_done");
        chk("os_irq_hi", {31'h0, bus_if.IRQ}, 32'h1);
        peek(2'd0, v); chk("os_ctrl8", v, 32'h8);
        idle(2, "os_hold");
        chk("os_irq_held", {31'h0, bus_if.IRQ}, 32'h1);
        step(2'd0, 1'b1, 32'h0, "os_clr");
        chk("os_irq_cleared", {31'h0, bus_if.IRQ}, 32'h0);

        // Auto-reload, PRESET=2: pulse every 4 cycles
        step(2'd1, 1'b1, 32'd2, "ar_pre");
        step(2'd0, 1'b1, 32'hB, "ar_ctl");
        for (int i = 0; i < 16; i++) begin
            idle(1, "ar_run");
            irq_hist[i] = bus_if.IRQ;
        end
        chk("ar_irq_pattern", {16'h0, irq_hist}, 32'h8888);
        step(2'd0, 1'b1, 32'h0, "ar_stop");
        idle(4, "ar_idle");

        // Masked one-shot, PRESET=1
        step(2'd1, 1'b1, 32'd1, "im_pre");
        step(2'd0, 1'b1, 32'h1, "im_ctl");
        idle(6, "im_run");
        peek(2'd2, v); chk("im_count0", v, 32'h0);
        peek(2'd0, v); chk("im_en_clr", v, 32'h0);
        chk("im_irq_lo", {31'h0, bus_if.IRQ}, 32'h0);

        // PRESET=0 in auto-reload: INT three cycles after enable
        step(2'd1, 1'b1, 32'd0, "p0_pre");
        step(2'd0, 1'b1, 32'hB, "p0_ctl");
        for (int i = 0; i < 3; i++) begin
            idle(1, "p0_run");
            irq3[i] = bus_if.IRQ;
        end
        chk("p0_int_at3", {29'h0, irq3}, 32'h4);
        step(2'd0, 1'b1, 32'h0, "p0_stop");
        idle(3, "p0_idle");

        // CTRL write in the INT cycle keeps EN and restarts
        step(2'd1, 1'b1, 32'd3, "sim_pre");
        step(2'd0, 1'b1, 32'h9, "sim_ctl");
        idle(5, "sim_run");
        step(2'd0, 1'b1, 32'h9, "sim_int_wr");
        peek(2'd0, v); chk("sim_en_kept", v, 32'h9);
        idle(2, "sim_reload");
        peek(2'd2, v); chk("sim_count3", v, 32'd3);
        // PRESET write mid-count affects only the next run
        step(2'd1, 1'b1, 32'd5, "sim_pre5");
        peek(2'd2, v); chk("sim_count_unaff", v, 32'd2);
        idle(4, "sim_finish");
        step(2'd0, 1'b1, 32'h9, "sim_ctl2");
        idle(2, "sim_load5");
        peek(2'd2, v); chk("sim_count5", v, 32'd5);
        idle(8, "sim_tail");

        // Random bus traffic
        for (int i = 0; i < 400; i++) begin
            ra  = 2'($urandom_range(0, 3));
            rwe = ($urandom_range(0, 3) == 0);
            rwd = (ra == 2'd1) ? 32'($urandom_range(0, 6)) : 32'($urandom);
            step(ra, rwe, rwd, "rnd");
        end

        // Async reset while COUNT=7
        step(2'd0, 1'b1, 32'h0, "ar7_stop");
        idle(3, "ar7_idle");
        step(2'd1, 1'b1, 32'd10, "ar7_pre");
        step(2'd0, 1'b1, 32'h9, "ar7_ctl");
        for (int i = 0; i < 20; i++) begin
            if (m_count == 32'd7 && m_phase == PH_CNT) break;
            idle(1, "ar7_run");
        end
        peek(2'd2, v); chk("ar7_pre_reset_count", v, 32'd7);
        rst = 1'b0;
        #1;
        chk("ar7_count_now", bus_if.RD, 32'h0);
        chk("ar7_irq_now", {31'h0, bus_if.IRQ}, 32'h0);
        model_reset();
        idle(2, "ar7_held");
        rst = 1'b1;
        idle(4, "ar7_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
